// File: rtl/forth_loader.sv
// Byte-stream program loader for the Forth core: frames are written into instruction RAM, and the core is released on success.
// Optional FORTH_LOADER_CHK_EN adds a trailing XOR checksum byte per frame.
module forth_loader #(
    parameter int unsigned IADDR_WIDTH = 10,
    parameter int unsigned INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IADDR_WIDTH-1:0] iaddr,
    output logic [INSTR_WIDTH-1:0] idata,
    output logic                   core_reset,
    output logic                   load_busy,
    output logic                   load_err
);

    localparam int unsigned DEPTH = 1 << IADDR_WIDTH;
    localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(16'hE040);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CNT_H  = 3'd1,
        S_CNT_L  = 3'd2,
        S_DATA_H = 3'd3,
        S_DATA_L = 3'd4,
`ifdef FORTH_LOADER_CHK_EN
        S_CHK    = 3'd5,
`endif
        S_RUN    = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [7:0]             r_cnt_hi;
    logic [7:0]             r_data_hi;
    logic [15:0]            r_count;
    // One bit wider than the RAM index so a full-depth frame never wraps.
    logic [IADDR_WIDTH:0]   r_waddr;
    logic [INSTR_WIDTH-1:0] r_mem [DEPTH];
`ifdef FORTH_LOADER_CHK_EN
    logic [7:0]             r_chk;
`endif
    logic                   w_acc;
    logic                   w_we;
    logic                   w_last;
    logic [15:0]            w_count;

    assign in_ready = reset;
    assign w_acc    = in_valid & in_ready;
    assign w_count  = {r_cnt_hi, in_data};
    assign w_last   = (32'(r_waddr) + 32'd1) == 32'(r_count);

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        load_busy   = 1'b0;
        case (r_state)
            S_CNT_H, S_CNT_L, S_DATA_H, S_DATA_L: load_busy = 1'b1;
`ifdef FORTH_LOADER_CHK_EN
            S_CHK:                                load_busy = 1'b1;
`endif
            default:                              load_busy = 1'b0;
        endcase
        if (w_acc) begin
            case (r_state)
                S_IDLE, S_RUN, S_ERR: begin
                    if (in_data == SYNC) w_state_nxt = S_CNT_H;
                end
                S_CNT_H: w_state_nxt = S_CNT_L;
                S_CNT_L: begin
                    if (w_count == 16'd0 || 32'(w_count) > DEPTH) w_state_nxt = S_ERR;
                    else                                          w_state_nxt = S_DATA_H;
                end
                S_DATA_H: w_state_nxt = S_DATA_L;
                S_DATA_L: begin
                    w_we = 1'b1;
                    if (w_last) begin
`ifdef FORTH_LOADER_CHK_EN
                        w_state_nxt = S_CHK;
`else
                        w_state_nxt = S_RUN;
`endif
                    end else begin
                        w_state_nxt = S_DATA_H;
                    end
                end
`ifdef FORTH_LOADER_CHK_EN
                S_CHK: w_state_nxt = (in_data == r_chk) ? S_RUN : S_ERR;
`endif
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            core_reset <= 1'b1;
            load_err   <= 1'b0;
            idata      <= NOP;
            r_waddr    <= '0;
            r_cnt_hi   <= '0;
            r_data_hi  <= '0;
            r_count    <= '0;
`ifdef FORTH_LOADER_CHK_EN
            r_chk      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            core_reset <= (w_state_nxt != S_RUN);
            load_err   <= (w_state_nxt == S_ERR);
            idata      <= r_mem[iaddr];
            if (w_acc) begin
                case (r_state)
                    S_IDLE, S_RUN, S_ERR: begin
                        if (in_data == SYNC) begin
                            r_waddr <= '0;
`ifdef FORTH_LOADER_CHK_EN
                            r_chk   <= '0;
`endif
                        end
                    end
                    S_CNT_H: r_cnt_hi <= in_data;
                    S_CNT_L: r_count  <= w_count;
                    S_DATA_H: begin
                        r_data_hi <= in_data;
`ifdef FORTH_LOADER_CHK_EN
                        r_chk     <= r_chk ^ in_data;
`endif
                    end
                    S_DATA_L: begin
                        r_waddr <= r_waddr + 1'b1;
`ifdef FORTH_LOADER_CHK_EN
                        r_chk   <= r_chk ^ in_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    // RAM has no reset so contents survive a mid-frame abort.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_waddr[IADDR_WIDTH-1:0]] <= INSTR_WIDTH'({r_data_hi, in_data});
    end

endmodule
